// File: rtl/regfile_pkg.sv
// Shared constants, index type and write-port hit counting for the register file.
// Helper sizes cap the generic hit counter at 8 write ports of up to 8-bit indices.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 4;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_WR     = 8;
  localparam int WIDE_W     = MAX_WR * MAX_ADDR_W;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  localparam reg_idx_t NULL_REG = '1;

  // The all-ones index of the caller's width is the null register and never counts as a hit.
  function automatic int countHits(input logic [WIDE_W-1:0] addrs, input int numWr,
                                   input int addrW, input logic [MAX_ADDR_W-1:0] idx);
    logic [MAX_ADDR_W-1:0] mask;
    logic [MAX_ADDR_W-1:0] cur;
    int hits;
    mask = (MAX_ADDR_W'(1) << addrW) - MAX_ADDR_W'(1);
    hits = 0;
    for (int k = 0; k < MAX_WR; k++) begin
      cur = MAX_ADDR_W'(addrs >> (k * addrW)) & mask;
      if (k < numWr && cur == idx && cur != mask) hits++;
    end
    return hits;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback and mark-pending signals of the scoreboarded register file.
interface regfile_sb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
  logic [NUM_WR*DATA_W-1:0] wr_data_i;
  logic [ADDR_W-1:0]        mark_addr_i;
  logic                     mark_ok_o;
  logic                     underflow_o;

  modport master (
    output rd_addr_i, wr_addr_i, wr_data_i, mark_addr_i,
    input  rd_data_o, rd_busy_o, mark_ok_o, underflow_o
  );

  modport slave (
    input  rd_addr_i, wr_addr_i, wr_data_i, mark_addr_i,
    output rd_data_o, rd_busy_o, mark_ok_o, underflow_o
  );

endinterface

// File: rtl/regfile_sb_counter.sv
// Saturating pending-write counter for one register: +1 per accepted mark, -dec per writeback.
// Going below zero clamps to zero and raises a one-cycle underflow pulse.
module sb_counter #(
  parameter int PEND_W = 2,
  parameter int DEC_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic [DEC_W-1:0]  dec_i,
  output logic [PEND_W-1:0] count_o,
  output logic              at_max_o,
  output logic              is_zero_o,
  output logic              underflow_o
);

  localparam int SUM_W = PEND_W + DEC_W + 1;

  logic [PEND_W-1:0] count_q, count_d;
  logic [SUM_W-1:0]  sum;
  logic              uflow;

  // inc is only granted when it cannot overflow, so only the low side needs clamping.
  always_comb begin
    sum     = SUM_W'(count_q) + SUM_W'(inc_i);
    uflow   = sum < SUM_W'(dec_i);
    count_d = uflow ? '0 : PEND_W'(sum - SUM_W'(dec_i));
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o     = count_q;
  assign at_max_o    = &count_q;
  assign is_zero_o   = ~|count_q;
  assign underflow_o = uflow;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port architectural register file with per-register pending-write scoreboard
// and optional same-cycle writeback-to-decode forwarding of data and busy.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1
) (
  input logic          clk_i,
  input logic          rst_n,
  regfile_sb_if.slave  bus
);

  localparam int NREG  = 2 ** ADDR_W - 1;
  localparam int DEC_W = $clog2(NUM_WR + 1);
  localparam logic [ADDR_W-1:0] NULL_IDX = '1;

  logic [DATA_W-1:0] regFile_q [NREG];
  logic [DATA_W-1:0] regFile_d [NREG];
  logic [PEND_W-1:0] count [NREG];
  logic [NREG-1:0]   atMax, isZero, ufPulse;
  logic              underflow_q, underflow_d;
  logic [ADDR_W-1:0] markAddr, rdAddr, wrAddr;
  logic              markOk, markAccept;
  logic [WIDE_W-1:0] wrAddrWide;

  assign wrAddrWide = WIDE_W'(bus.wr_addr_i);
  assign markAddr   = bus.mark_addr_i;

  // Ascending port order makes the highest-numbered port win an index conflict.
  always_comb begin
    regFile_d = regFile_q;
    wrAddr    = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wrAddr = bus.wr_addr_i[k*ADDR_W +: ADDR_W];
      if (wrAddr != NULL_IDX) regFile_d[wrAddr] = bus.wr_data_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regFile_q[r] <= '0;
      underflow_q <= 1'b0;
    end else begin
      regFile_q   <= regFile_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow_d = underflow_q | (|ufPulse);

  // A full counter can still take a mark when a writeback drains it in the same cycle.
  always_comb begin
    markOk = 1'b1;
    if (markAddr != NULL_IDX && atMax[markAddr] &&
        countHits(wrAddrWide, NUM_WR, ADDR_W, MAX_ADDR_W'(markAddr)) == 0)
      markOk = 1'b0;
  end

  assign markAccept = markOk && (markAddr != NULL_IDX);

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    logic [DEC_W-1:0] dec;
    logic             inc;
    assign dec = DEC_W'(countHits(wrAddrWide, NUM_WR, ADDR_W, MAX_ADDR_W'(r)));
    assign inc = markAccept && (markAddr == ADDR_W'(r));
    sb_counter #(.PEND_W(PEND_W), .DEC_W(DEC_W)) u_cnt (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .inc_i       (inc),
      .dec_i       (dec),
      .count_o     (count[r]),
      .at_max_o    (atMax[r]),
      .is_zero_o   (isZero[r]),
      .underflow_o (ufPulse[r])
    );
  end

  // Outputs are forced to their idle values while reset is held, even with bypass data present.
  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    rdAddr        = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdAddr = bus.rd_addr_i[p*ADDR_W +: ADDR_W];
      if (rst_n && rdAddr != NULL_IDX) begin
        bus.rd_data_o[p*DATA_W +: DATA_W] = regFile_q[rdAddr];
        if (BYPASS != 0) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wr_addr_i[k*ADDR_W +: ADDR_W] == rdAddr)
              bus.rd_data_o[p*DATA_W +: DATA_W] = bus.wr_data_i[k*DATA_W +: DATA_W];
          end
          bus.rd_busy_o[p] = int'(count[rdAddr]) >
                             countHits(wrAddrWide, NUM_WR, ADDR_W, MAX_ADDR_W'(rdAddr));
        end else begin
          bus.rd_busy_o[p] = !isZero[rdAddr];
        end
      end
    end
  end

  assign bus.mark_ok_o   = !rst_n || markOk;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: drives a BYPASS=1 and a BYPASS=0 instance in lockstep and
// compares both against an array/integer reference model plus directed scenarios.
module tb_regfile_sb;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NULLR = 15;
  localparam int MAXC = 3;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rdAddr;
  logic [7:0]    wrAddr;
  logic [127:0]  wrData;
  logic [3:0]    markAddr;
  int            vectors;
  int            miscompares;

  logic [DW-1:0] mReg [16];
  int            mCnt [16];
  bit            mUf;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2)) ifB ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2)) ifN ();

  assign ifB.rd_addr_i = rdAddr;    assign ifN.rd_addr_i = rdAddr;
  assign ifB.wr_addr_i = wrAddr;    assign ifN.wr_addr_i = wrAddr;
  assign ifB.wr_data_i = wrData;    assign ifN.wr_data_i = wrData;
  assign ifB.mark_addr_i = markAddr; assign ifN.mark_addr_i = markAddr;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .PEND_W(2), .BYPASS(1))
    dutB (.clk_i(clk), .rst_n(rst_n), .bus(ifB));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .PEND_W(2), .BYPASS(0))
    dutN (.clk_i(clk), .rst_n(rst_n), .bus(ifN));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dutData(input int b, input int p);
    return (b != 0) ? ifB.rd_data_o[p*DW +: DW] : ifN.rd_data_o[p*DW +: DW];
  endfunction
  function automatic logic dutBusy(input int b, input int p);
    return (b != 0) ? ifB.rd_busy_o[p] : ifN.rd_busy_o[p];
  endfunction
  function automatic logic dutMarkOk(input int b);
    return (b != 0) ? ifB.mark_ok_o : ifN.mark_ok_o;
  endfunction
  function automatic logic dutUf(input int b);
    return (b != 0) ? ifB.underflow_o : ifN.underflow_o;
  endfunction

  // Reference model: writeback count per register, last-port-wins data, signed pending counts.
  function automatic int clearsOf(input int r);
    int n;
    n = 0;
    if (r == NULLR) return 0;
    for (int k = 0; k < 2; k++) if (int'(wrAddr[k*4 +: 4]) == r) n++;
    return n;
  endfunction
  function automatic bit expMarkOk();
    if (!rst_n || int'(markAddr) == NULLR) return 1'b1;
    return !(mCnt[markAddr] == MAXC && clearsOf(int'(markAddr)) == 0);
  endfunction
  function automatic logic [DW-1:0] expData(input int p, input int byp);
    int a;
    logic [DW-1:0] d;
    a = int'(rdAddr[p*4 +: 4]);
    if (!rst_n || a == NULLR) return '0;
    d = mReg[a];
    if (byp != 0)
      for (int k = 0; k < 2; k++) if (int'(wrAddr[k*4 +: 4]) == a) d = wrData[k*DW +: DW];
    return d;
  endfunction
  function automatic logic expBusy(input int p, input int byp);
    int a;
    a = int'(rdAddr[p*4 +: 4]);
    if (!rst_n || a == NULLR) return 1'b0;
    return (byp != 0) ? (mCnt[a] - clearsOf(a) > 0) : (mCnt[a] != 0);
  endfunction

  task automatic modelReset();
    for (int r = 0; r < 16; r++) begin mReg[r] = '0; mCnt[r] = 0; end
    mUf = 1'b0;
  endtask

  task automatic commitModel();
    int clr [16];
    bit ok;
    int n;
    if (!rst_n) return;
    ok = expMarkOk();
    for (int r = 0; r < 16; r++) clr[r] = clearsOf(r);
    for (int k = 0; k < 2; k++)
      if (int'(wrAddr[k*4 +: 4]) != NULLR) mReg[wrAddr[k*4 +: 4]] = wrData[k*DW +: DW];
    for (int r = 0; r < NULLR; r++) begin
      n = mCnt[r] + ((ok && int'(markAddr) == r) ? 1 : 0) - clr[r];
      if (n < 0) begin n = 0; mUf = 1'b1; end
      mCnt[r] = n;
    end
  endtask

  task automatic applyStimulus(input int ra0, input int ra1, input int wa0, input logic [DW-1:0] wd0,
                               input int wa1, input logic [DW-1:0] wd1, input int ma);
    rdAddr   = {4'(ra1), 4'(ra0)};
    wrAddr   = {4'(wa1), 4'(wa0)};
    wrData   = {wd1, wd0};
    markAddr = 4'(ma);
  endtask

  task automatic stepClock();
    @(posedge clk);
    commitModel();
    @(negedge clk);
  endtask

  task automatic applyIdle();
    applyStimulus(NULLR, NULLR, NULLR, '0, NULLR, '0, NULLR);
  endtask

  task automatic applyReset();
    @(negedge clk);
    applyIdle();
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    applyIdle();
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutMarkOk(b) !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_markok dut%0d got %b want 1", b, dutMarkOk(b)); end
      vectors++; if (dutUf(b) !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_uf dut%0d got %b want 0", b, dutUf(b)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(NULLR, NULLR, 3, 64'hDEAD, NULLR, '0, NULLR);
    stepClock();
    applyStimulus(3, NULLR, NULLR, '0, NULLR, '0, 3);
    #1;
    vectors++; if (dutData(1, 0) !== 64'hDEAD) begin miscompares++; $display("[TB] FAIL rst_load got %h want dead", dutData(1, 0)); end
    stepClock();
    applyStimulus(3, 5, 5, 64'h55, NULLR, '0, 3);
    #1;
    vectors++; if (dutBusy(0, 0) !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_prebusy got %b want 1", dutBusy(0, 0)); end
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 2; p++) begin
        vectors++; if (dutData(b, p) !== '0) begin miscompares++; $display("[TB] FAIL rst_data dut%0d p%0d got %h want 0", b, p, dutData(b, p)); end
        vectors++; if (dutBusy(b, p) !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy dut%0d p%0d got %b want 0", b, p, dutBusy(b, p)); end
      end
      vectors++; if (dutMarkOk(b) !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_markok2 dut%0d got %b want 1", b, dutMarkOk(b)); end
      vectors++; if (dutUf(b) !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_uf2 dut%0d got %b want 0", b, dutUf(b)); end
    end
    @(negedge clk);
    applyStimulus(3, NULLR, NULLR, '0, NULLR, '0, NULLR);
    rst_n = 1'b1;
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutData(b, 0) !== '0) begin miscompares++; $display("[TB] FAIL rst_after_data dut%0d got %h want 0", b, dutData(b, 0)); end
      vectors++; if (dutBusy(b, 0) !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_after_busy dut%0d got %b want 0", b, dutBusy(b, 0)); end
    end
    stepClock();
  endtask

  task automatic test_underflow();
    applyStimulus(9, NULLR, NULLR, '0, 9, 64'h99, NULLR);
    #1;
    vectors++; if (dutUf(1) !== 1'b0) begin miscompares++; $display("[TB] FAIL uf_before got %b want 0", dutUf(1)); end
    stepClock();
    applyStimulus(9, NULLR, NULLR, '0, NULLR, '0, 9);
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutUf(b) !== 1'b1) begin miscompares++; $display("[TB] FAIL uf_set dut%0d got %b want 1", b, dutUf(b)); end
      vectors++; if (dutData(b, 0) !== 64'h99) begin miscompares++; $display("[TB] FAIL uf_data dut%0d got %h want 99", b, dutData(b, 0)); end
      vectors++; if (dutBusy(b, 0) !== 1'b0) begin miscompares++; $display("[TB] FAIL uf_busy0 dut%0d got %b want 0", b, dutBusy(b, 0)); end
    end
    stepClock();
    applyStimulus(9, NULLR, 9, 64'h9A, NULLR, '0, NULLR);
    #1;
    vectors++; if (dutBusy(0, 0) !== 1'b1) begin miscompares++; $display("[TB] FAIL uf_busy1 got %b want 1", dutBusy(0, 0)); end
    stepClock();
    applyStimulus(9, NULLR, NULLR, '0, NULLR, '0, NULLR);
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutBusy(b, 0) !== 1'b0) begin miscompares++; $display("[TB] FAIL uf_drain dut%0d got %b want 0", b, dutBusy(b, 0)); end
      vectors++; if (dutUf(b) !== 1'b1) begin miscompares++; $display("[TB] FAIL uf_sticky dut%0d got %b want 1", b, dutUf(b)); end
    end
    applyReset();
    #1;
    vectors++; if (dutUf(1) !== 1'b0) begin miscompares++; $display("[TB] FAIL uf_cleared got %b want 0", dutUf(1)); end
  endtask

  task automatic test_bypass();
    applyStimulus(5, NULLR, 5, 64'h1234, NULLR, '0, NULLR);
    #1;
    vectors++; if (dutData(1, 0) !== 64'h1234) begin miscompares++; $display("[TB] FAIL byp_same got %h want 1234", dutData(1, 0)); end
    vectors++; if (dutData(0, 0) !== '0) begin miscompares++; $display("[TB] FAIL nobyp_same got %h want 0", dutData(0, 0)); end
    stepClock();
    applyStimulus(5, NULLR, NULLR, '0, NULLR, '0, NULLR);
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutData(b, 0) !== 64'h1234) begin miscompares++; $display("[TB] FAIL byp_after dut%0d got %h want 1234", b, dutData(b, 0)); end
    end
  endtask

  task automatic test_conflict();
    applyStimulus(NULLR, 2, 2, 64'hAAAA, 2, 64'hBBBB, NULLR);
    #1;
    vectors++; if (dutData(1, 1) !== 64'hBBBB) begin miscompares++; $display("[TB] FAIL conf_byp got %h want bbbb", dutData(1, 1)); end
    stepClock();
    applyStimulus(NULLR, 2, NULLR, '0, NULLR, '0, NULLR);
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutData(b, 1) !== 64'hBBBB) begin miscompares++; $display("[TB] FAIL conf_after dut%0d got %h want bbbb", b, dutData(b, 1)); end
    end
  endtask

  task automatic test_null();
    applyStimulus(NULLR, NULLR, NULLR, 64'hFFFF, NULLR, 64'hFFFF, NULLR);
    #1;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 2; p++) begin
        vectors++; if (dutData(b, p) !== '0) begin miscompares++; $display("[TB] FAIL null_data dut%0d p%0d got %h want 0", b, p, dutData(b, p)); end
        vectors++; if (dutBusy(b, p) !== 1'b0) begin miscompares++; $display("[TB] FAIL null_busy dut%0d p%0d got %b want 0", b, p, dutBusy(b, p)); end
      end
      vectors++; if (dutMarkOk(b) !== 1'b1) begin miscompares++; $display("[TB] FAIL null_markok dut%0d got %b want 1", b, dutMarkOk(b)); end
    end
    stepClock();
    applyStimulus(NULLR, 0, NULLR, '0, NULLR, '0, NULLR);
    #1;
    vectors++; if (dutData(1, 0) !== '0) begin miscompares++; $display("[TB] FAIL null_after got %h want 0", dutData(1, 0)); end
    vectors++; if (dutBusy(1, 1) !== 1'b0) begin miscompares++; $display("[TB] FAIL null_r0busy got %b want 0", dutBusy(1, 1)); end
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(7, NULLR, NULLR, '0, NULLR, '0, 7);
      #1;
      vectors++; if (dutMarkOk(1) !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_mark%0d got %b want 1", i, dutMarkOk(1)); end
      stepClock();
    end
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutMarkOk(b) !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_full dut%0d got %b want 0", b, dutMarkOk(b)); end
    end
    stepClock();
    applyStimulus(7, NULLR, 7, 64'h77, NULLR, '0, 7);
    #1;
    vectors++; if (dutBusy(0, 0) !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_ignored got %b want 1", dutBusy(0, 0)); end
    vectors++; if (dutMarkOk(1) !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_markclr got %b want 1", dutMarkOk(1)); end
    vectors++; if (dutBusy(1, 0) !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_bypbusy got %b want 1", dutBusy(1, 0)); end
    stepClock();
    applyStimulus(7, NULLR, 7, 64'h78, NULLR, '0, NULLR);
    stepClock();
    applyStimulus(7, NULLR, 7, 64'h79, 7, 64'h7A, NULLR);
    #1;
    vectors++; if (dutBusy(0, 0) !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_busy2 got %b want 1", dutBusy(0, 0)); end
    vectors++; if (dutBusy(1, 0) !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_bypdrain got %b want 0", dutBusy(1, 0)); end
    stepClock();
    applyStimulus(7, NULLR, NULLR, '0, NULLR, '0, NULLR);
    #1;
    for (int b = 0; b < 2; b++) begin
      vectors++; if (dutBusy(b, 0) !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_done dut%0d got %b want 0", b, dutBusy(b, 0)); end
      vectors++; if (dutData(b, 0) !== 64'h7A) begin miscompares++; $display("[TB] FAIL sb_data dut%0d got %h want 7a", b, dutData(b, 0)); end
    end
  endtask

  // Small index range concentrates traffic so conflicts, saturation and drains all occur.
  function automatic int randAddr();
    int v;
    v = int'($urandom_range(0, 5));
    return (v == 5) ? NULLR : v;
  endfunction

  task automatic test_random();
    int wa0, wa1;
    for (int c = 0; c < 400; c++) begin
      wa0 = ($urandom_range(0, 2) == 0) ? randAddr() : NULLR;
      wa1 = ($urandom_range(0, 2) == 0) ? randAddr() : NULLR;
      applyStimulus(randAddr(), randAddr(), wa0, {$urandom, $urandom}, wa1, {$urandom, $urandom},
                    ($urandom_range(0, 1) == 0) ? randAddr() : NULLR);
      #1;
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < 2; p++) begin
          vectors++; if (dutData(b, p) !== expData(p, b)) begin miscompares++; $display("[TB] FAIL rnd_data c%0d dut%0d p%0d got %h want %h", c, b, p, dutData(b, p), expData(p, b)); end
          vectors++; if (dutBusy(b, p) !== expBusy(p, b)) begin miscompares++; $display("[TB] FAIL rnd_busy c%0d dut%0d p%0d got %b want %b", c, b, p, dutBusy(b, p), expBusy(p, b)); end
        end
        vectors++; if (dutMarkOk(b) !== expMarkOk()) begin miscompares++; $display("[TB] FAIL rnd_markok c%0d dut%0d got %b want %b", c, b, dutMarkOk(b), expMarkOk()); end
        vectors++; if (dutUf(b) !== mUf) begin miscompares++; $display("[TB] FAIL rnd_uf c%0d dut%0d got %b want %b", c, b, dutUf(b), mUf); end
      end
      stepClock();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    modelReset();
    applyIdle();
    $display("[TB] starting regfile_sb bench");
    test_reset();
    test_underflow();
    test_bypass();
    test_conflict();
    test_null();
    test_scoreboard();
    applyReset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
